// File: rtl/demux_pkg.sv
// Shared constants and target-mask helper for the stream demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_DATA_W    = 8;
  localparam int unsigned DEMUX_NUM_CH    = 8;
  localparam int unsigned DEMUX_MAX_CH    = 64;
  localparam int unsigned DEMUX_SEL_MAX_W = 6;

  // Mask is sized for the largest supported channel count; bits at or above
  // num_ch are always 0, and an out-of-range unicast select yields an empty mask.
  function automatic logic [DEMUX_MAX_CH-1:0] onehot_sel(
    input logic [DEMUX_SEL_MAX_W-1:0] sel,
    input logic                       bcast,
    input int unsigned                num_ch
  );
    logic [DEMUX_MAX_CH-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < DEMUX_MAX_CH; i++) begin
      if (i < num_ch && (bcast || 32'(sel) == i)) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry holding register with valid/ready handshake for a single output channel.
module demux_chan_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              valid,
  input  logic              ready,
  output logic              can_accept
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  assign can_accept = !valid_q || ready;

  // A load in the same cycle as a drain keeps valid high with the new word.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = d;
      valid_d = 1'b1;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/stream_demux_n.sv
// Registered 1:NUM_CH stream demultiplexer with broadcast and invalid-select reporting.
module stream_demux_n
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEMUX_DATA_W,
  parameter int unsigned NUM_CH = DEMUX_NUM_CH,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     err_sel
);

  logic [DEMUX_MAX_CH-1:0] mask_full;
  logic [DEMUX_MAX_CH-1:0] can_accept_ext;
  logic [NUM_CH-1:0]       can_accept;
  logic [NUM_CH-1:0]       load;
  logic                    accept;
  logic                    err_sel_q, err_sel_d;

  assign mask_full = onehot_sel(DEMUX_SEL_MAX_W'(in_sel), in_bcast, NUM_CH);

  // Channels beyond NUM_CH never appear in the mask; treating them as ready
  // lets the all-or-nothing reduction run over the full-width mask.
  always_comb begin
    can_accept_ext             = '1;
    can_accept_ext[NUM_CH-1:0] = can_accept;
  end

  assign in_ready  = ~|(mask_full & ~can_accept_ext);
  assign accept    = in_valid && in_ready;
  assign load      = mask_full[NUM_CH-1:0] & {NUM_CH{accept}};
  assign err_sel_d = accept && ~|mask_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sel_q <= 1'b0;
    end else begin
      err_sel_q <= err_sel_d;
    end
  end

  assign err_sel = err_sel_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    demux_chan_reg #(
      .DATA_W(DATA_W)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load[c]),
      .d          (in_data),
      .q          (out_data[c*DATA_W +: DATA_W]),
      .valid      (out_valid[c]),
      .ready      (out_ready[c]),
      .can_accept (can_accept[c])
    );
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed and scoreboarded checks for stream_demux_n at NUM_CH=8 and NUM_CH=6.
module tb_stream_demux_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  d8_in_data;
  logic [2:0]  d8_in_sel;
  logic        d8_in_bcast, d8_in_valid, d8_in_ready, d8_err;
  logic [63:0] d8_out_data;
  logic [7:0]  d8_out_valid, d8_out_ready;

  logic [7:0]  d6_in_data;
  logic [2:0]  d6_in_sel;
  logic        d6_in_bcast, d6_in_valid, d6_in_ready, d6_err;
  logic [47:0] d6_out_data;
  logic [5:0]  d6_out_valid, d6_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  stream_demux_n #(.DATA_W(8), .NUM_CH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(d8_in_data), .in_sel(d8_in_sel),
    .in_bcast(d8_in_bcast), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .out_data(d8_out_data), .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .err_sel(d8_err)
  );

  stream_demux_n #(.DATA_W(8), .NUM_CH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(d6_in_data), .in_sel(d6_in_sel),
    .in_bcast(d6_in_bcast), .in_valid(d6_in_valid), .in_ready(d6_in_ready),
    .out_data(d6_out_data), .out_valid(d6_out_valid), .out_ready(d6_out_ready),
    .err_sel(d6_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    d8_in_valid = 1'b1; d8_in_sel = 3'd2; d8_in_data = 8'h33; d8_in_bcast = 1'b0;
    d8_out_ready = 8'h00;
    d6_in_valid = 1'b1; d6_in_sel = 3'd7; d6_in_data = 8'hFF; d6_in_bcast = 1'b0;
    d6_out_ready = 6'h00;
    tick();
    tick();
    n_checks++;
    if (d8_out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid8: got %h expected 00", d8_out_valid); end
    n_checks++;
    if (d8_out_data !== 64'h0) begin n_fail++; $display("FAIL reset_data8: got %h expected 0", d8_out_data); end
    n_checks++;
    if (d8_err !== 1'b0) begin n_fail++; $display("FAIL reset_err8: got %b expected 0", d8_err); end
    n_checks++;
    if (d6_out_valid !== 6'h00 || d6_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_dut6: valid %h err %b expected 00 0", d6_out_valid, d6_err);
    end
    rst_n = 1'b1;
    d6_in_valid = 1'b0;
    #1;
    n_checks++;
    if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", d8_in_ready); end
    tick();
    d8_in_valid = 1'b0;
    n_checks++;
    if (d8_out_valid !== 8'h04 || d8_out_data[23:16] !== 8'h33) begin
      n_fail++; $display("FAIL first_accept: valid %h data %h expected 04 33", d8_out_valid, d8_out_data[23:16]);
    end
    n_checks++;
    if (d6_err !== 1'b0) begin n_fail++; $display("FAIL reset_no_err6: got %b expected 0", d6_err); end
    d8_out_ready = 8'hFF;
    tick();
    n_checks++;
    if (d8_out_valid !== 8'h00) begin n_fail++; $display("FAIL first_drain: got %h expected 00", d8_out_valid); end
  endtask

  task automatic test_unicast_walk();
    d8_out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      d8_in_valid = 1'b1; d8_in_sel = 3'(i); d8_in_data = 8'hA0 + 8'(i);
      #1;
      n_checks++;
      if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL walk_ready[%0d]: got %b expected 1", i, d8_in_ready); end
      tick();
      n_checks++;
      if (d8_out_valid !== 8'(1 << i) || d8_out_data[i*8 +: 8] !== 8'hA0 + 8'(i) || d8_err !== 1'b0) begin
        n_fail++;
        $display("FAIL walk_out[%0d]: valid %h data %h err %b expected %h %h 0",
                 i, d8_out_valid, d8_out_data[i*8 +: 8], d8_err, 8'(1 << i), 8'hA0 + 8'(i));
      end
    end
    d8_in_valid = 1'b0;
    tick();
    n_checks++;
    if (d8_out_valid !== 8'h00) begin n_fail++; $display("FAIL walk_drain: got %h expected 00", d8_out_valid); end
  endtask

  task automatic test_backpressure();
    d8_out_ready = 8'hF7;
    d8_in_valid = 1'b1; d8_in_sel = 3'd3; d8_in_data = 8'h11;
    #1;
    n_checks++;
    if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1: got %b expected 1", d8_in_ready); end
    tick();
    d8_in_data = 8'h22;
    #1;
    n_checks++;
    if (d8_out_valid[3] !== 1'b1 || d8_out_data[31:24] !== 8'h11) begin
      n_fail++; $display("FAIL bp_first: valid %b data %h expected 1 11", d8_out_valid[3], d8_out_data[31:24]);
    end
    n_checks++;
    if (d8_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready2: got %b expected 0", d8_in_ready); end
    tick();
    n_checks++;
    if (d8_out_valid !== 8'h08 || d8_out_data[31:24] !== 8'h11) begin
      n_fail++; $display("FAIL bp_hold: valid %h data %h expected 08 11", d8_out_valid, d8_out_data[31:24]);
    end
    d8_out_ready = 8'hFF;
    #1;
    n_checks++;
    if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready3: got %b expected 1", d8_in_ready); end
    tick();
    d8_in_valid = 1'b0;
    n_checks++;
    if (d8_out_valid !== 8'h08 || d8_out_data[31:24] !== 8'h22) begin
      n_fail++; $display("FAIL bp_reload: valid %h data %h expected 08 22", d8_out_valid, d8_out_data[31:24]);
    end
    tick();
    n_checks++;
    if (d8_out_valid !== 8'h00) begin n_fail++; $display("FAIL bp_drain: got %h expected 00", d8_out_valid); end
  endtask

  task automatic test_broadcast();
    d8_out_ready = 8'hDF;
    d8_in_valid = 1'b1; d8_in_sel = 3'd5; d8_in_data = 8'h55; d8_in_bcast = 1'b0;
    tick();
    d8_in_bcast = 1'b1; d8_in_data = 8'h5A; d8_in_sel = 3'd0;
    #1;
    n_checks++;
    if (d8_in_ready !== 1'b0) begin n_fail++; $display("FAIL bc_blocked: got %b expected 0", d8_in_ready); end
    tick();
    n_checks++;
    if (d8_out_valid !== 8'h20 || d8_out_data[47:40] !== 8'h55) begin
      n_fail++; $display("FAIL bc_nochange: valid %h data %h expected 20 55", d8_out_valid, d8_out_data[47:40]);
    end
    d8_out_ready = 8'hFF;
    #1;
    n_checks++;
    if (d8_in_ready !== 1'b1) begin n_fail++; $display("FAIL bc_ready: got %b expected 1", d8_in_ready); end
    tick();
    d8_in_valid = 1'b0; d8_in_bcast = 1'b0;
    n_checks++;
    if (d8_out_valid !== 8'hFF || d8_out_data !== {8{8'h5A}}) begin
      n_fail++; $display("FAIL bc_all: valid %h data %h expected ff 5a..5a", d8_out_valid, d8_out_data);
    end
    tick();
    n_checks++;
    if (d8_out_valid !== 8'h00) begin n_fail++; $display("FAIL bc_drain: got %h expected 00", d8_out_valid); end
  endtask

  task automatic test_invalid_sel();
    d6_out_ready = 6'h00;
    d6_in_valid = 1'b1; d6_in_sel = 3'd7; d6_in_data = 8'hFF; d6_in_bcast = 1'b0;
    #1;
    n_checks++;
    if (d6_in_ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready: got %b expected 1", d6_in_ready); end
    tick();
    d6_in_sel = 3'd6;
    n_checks++;
    if (d6_err !== 1'b1 || d6_out_valid !== 6'h00) begin
      n_fail++; $display("FAIL inv_sel7: err %b valid %h expected 1 00", d6_err, d6_out_valid);
    end
    tick();
    d6_in_sel = 3'd5;
    n_checks++;
    if (d6_err !== 1'b1 || d6_out_valid !== 6'h00) begin
      n_fail++; $display("FAIL inv_sel6: err %b valid %h expected 1 00", d6_err, d6_out_valid);
    end
    tick();
    d6_in_valid = 1'b0;
    n_checks++;
    if (d6_err !== 1'b0 || d6_out_valid !== 6'h20 || d6_out_data[47:40] !== 8'hFF) begin
      n_fail++; $display("FAIL valid_sel5: err %b valid %h data %h expected 0 20 ff", d6_err, d6_out_valid, d6_out_data[47:40]);
    end
    tick();
    n_checks++;
    if (d6_err !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b expected 0", d6_err); end
    d6_out_ready = 6'h3F;
    tick();
    n_checks++;
    if (d6_out_valid !== 6'h00) begin n_fail++; $display("FAIL inv_drain: got %h expected 00", d6_out_valid); end
  endtask

  task automatic test_random();
    logic [7:0] q [8][$];
    logic [7:0] mask, exp_valid;
    logic       hold, exp_ready;
    logic [7:0] wcnt;
    hold = 1'b0;
    wcnt = 8'h00;
    d8_in_valid = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!hold) begin
        d8_in_valid = 1'($urandom_range(0, 1));
        d8_in_sel   = 3'($urandom_range(0, 7));
        d8_in_bcast = ($urandom_range(0, 7) == 0);
        d8_in_data  = wcnt;
      end
      d8_out_ready = 8'($urandom);
      #1;
      mask = d8_in_bcast ? 8'hFF : 8'(1 << d8_in_sel);
      exp_ready = 1'b1;
      exp_valid = 8'h00;
      for (int c = 0; c < 8; c++) begin
        if (q[c].size() != 0) exp_valid[c] = 1'b1;
        if (mask[c] && q[c].size() != 0 && !d8_out_ready[c]) exp_ready = 1'b0;
      end
      n_checks++;
      if (d8_in_ready !== exp_ready) begin
        n_fail++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, d8_in_ready, exp_ready);
      end
      n_checks++;
      if (d8_out_valid !== exp_valid) begin
        n_fail++; $display("FAIL rnd_valid@%0d: got %h expected %h", cyc, d8_out_valid, exp_valid);
      end
      for (int c = 0; c < 8; c++) begin
        if (q[c].size() != 0) begin
          n_checks++;
          if (d8_out_data[c*8 +: 8] !== q[c][0]) begin
            n_fail++; $display("FAIL rnd_data@%0d ch%0d: got %h expected %h", cyc, c, d8_out_data[c*8 +: 8], q[c][0]);
          end
          if (d8_out_ready[c]) void'(q[c].pop_front());
        end
      end
      if (d8_in_valid && d8_in_ready) begin
        for (int c = 0; c < 8; c++) if (mask[c]) q[c].push_back(d8_in_data);
        wcnt = wcnt + 8'd1;
        hold = 1'b0;
      end else begin
        hold = d8_in_valid;
      end
      tick();
    end
    d8_in_valid = 1'b0;
    d8_out_ready = 8'hFF;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (q[c].size() != 0) begin
        n_checks++;
        if (d8_out_valid[c] !== 1'b1 || d8_out_data[c*8 +: 8] !== q[c][0]) begin
          n_fail++; $display("FAIL rnd_final ch%0d: valid %b data %h expected 1 %h", c, d8_out_valid[c], d8_out_data[c*8 +: 8], q[c][0]);
        end
        void'(q[c].pop_front());
      end
    end
    tick();
    n_checks++;
    if (d8_out_valid !== 8'h00) begin n_fail++; $display("FAIL rnd_empty: got %h expected 00", d8_out_valid); end
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (q[c].size() != 0) begin n_fail++; $display("FAIL rnd_leftover ch%0d: %0d words expected 0", c, q[c].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_unicast_walk();
    test_backpressure();
    test_broadcast();
    test_invalid_sel();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
